acc_readout: RTL

Result readout stage for the CIM macro datapath. It captures the final 51-bit accumulator sum on an end-of-accumulation strobe and applies a programmable arithmetic right shift, with optional rounding, followed by signed saturation to the output width. Each processed result is buffered in a small FIFO and delivered downstream on a valid/ready handshake. It consumes the accumulator's `nout` and sits between the accumulator and the output/writeback interface.

---
 rtl/acc_readout.sv | 125 ++++++++++++
 1 files changed

// File: rtl/acc_readout.sv
// Accumulator result readout: capture on acc_last, shift/round/saturate, then a small FIFO.
// Optional ACC_RD_ROUND_EN selects round-half-up instead of truncation.
module acc_readout #(
  parameter int unsigned ACC_W   = 51,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SHIFT_W = 6,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ACC_W-1:0]           acc_in,
  input  logic                       acc_last,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic                       ovf_clr,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } entry_t;

  logic                 s1_vld;
  logic [ACC_W-1:0]     s1_acc;
  logic [SHIFT_W-1:0]   s1_shift;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shr;
  logic [EXT_W-OUT_W:0]    hi;
  entry_t                  s2_entry;

  entry_t           mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;

  // S1: capture the final sum; the accumulator cannot be stalled
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld   <= 1'b0;
      s1_acc   <= '0;
      s1_shift <= '0;
    end else begin
      s1_vld <= acc_last;
      if (acc_last) begin
        s1_acc   <= acc_in;
        s1_shift <= shift;
      end
    end
  end

  // S2: sign-extend, optional rounding, arithmetic shift, saturate
  always_comb begin
    ext = {s1_acc[ACC_W-1], s1_acc};
    rnd = ext;
`ifdef ACC_RD_ROUND_EN
    if ((s1_shift != '0) && (32'(s1_shift) <= ACC_W)) begin
      rnd = ext + (EXT_W'(1) << (s1_shift - SHIFT_W'(1)));
    end
`endif
    // shifts of EXT_W or more leave only the sign fill
    shr = rnd >>> s1_shift;
    hi  = shr[EXT_W-1:OUT_W-1];
    s2_entry.sat  = 1'b0;
    s2_entry.data = shr[OUT_W-1:0];
    if (!((&hi) || !(|hi))) begin
      s2_entry.sat  = 1'b1;
      s2_entry.data = shr[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign count     = CNT_W'(wr_ptr - rd_ptr);
  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign do_push   = s1_vld && (!full || pop);
  assign drop      = s1_vld && full && !pop;
  assign out_data  = mem[rd_ptr[PTR_W-1:0]].data;
  assign out_sat   = mem[rd_ptr[PTR_W-1:0]].sat;

  // FIFO storage and pointers; the extra pointer bit distinguishes full from empty
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= s2_entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky drop flag; a same-cycle drop beats the clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
